// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave pair: frame width, divider
// counter width and the master state encoding.
package spi_pkg;

    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned DIV_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_TRANSFER,
        ST_STOP,
        ST_DONE
    } master_state_t;

endpackage

// File: rtl/spi_master.sv
// SPI mode-0 master: runs a single MSB-first frame after reset, then parks in DONE.
// spi_clk, mosi and cs are all driven straight from registers.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DIV_CLK = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [FRAME_BITS-1:0] i_tx_data,
    input  logic                  i_miso,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic                  o_cs,
    output logic [FRAME_BITS-1:0] o_rx_data,
    output logic                  o_tx_done,
    output logic                  o_rx_done
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CLK - 1);
    localparam logic [2:0]       BIT_LAST = 3'(FRAME_BITS - 1);

    master_state_t         r_state;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [2:0]            r_bit_cnt;
    logic [FRAME_BITS-1:0] r_tx_shift;
    logic [FRAME_BITS-1:0] r_rx_shift;
    logic [FRAME_BITS-1:0] r_rx_data;
    logic                  r_sclk;
    logic                  r_cs;
    logic                  r_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // cs drops together with the latch so bit 7 is on mosi for all of START
                    r_tx_shift <= i_tx_data;
                    r_cs       <= 1'b0;
                    r_div_cnt  <= '0;
                    r_state    <= ST_START;
                end
                ST_START: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        r_state   <= ST_TRANSFER;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                ST_TRANSFER: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        if (!r_sclk) begin
                            r_sclk     <= 1'b1;
                            r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], i_miso};
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_bit_cnt <= '0;
                                r_state   <= ST_STOP;
                            end else begin
                                r_bit_cnt  <= r_bit_cnt + 1'b1;
                                r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        r_cs      <= 1'b1;
                        r_rx_data <= r_rx_shift;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sclk    = r_sclk;
    assign o_mosi    = r_tx_shift[FRAME_BITS-1];
    assign o_cs      = r_cs;
    assign o_rx_data = r_rx_data;
    assign o_tx_done = r_done;
    assign o_rx_done = r_done;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave clocked by the system clock; bus edges are found by comparing
// spi_clk/cs against one-cycle-delayed copies.
module spi_slave
    import spi_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [FRAME_BITS-1:0] i_tx_data,
    input  logic                  i_sclk,
    input  logic                  i_mosi,
    input  logic                  i_cs,
    output logic                  o_miso,
    output logic [FRAME_BITS-1:0] o_rx_data,
    output logic                  o_tx_done,
    output logic                  o_rx_done
);

    localparam logic [3:0] BITS = 4'(FRAME_BITS);

    logic                  r_sclk_d;
    logic                  r_cs_d;
    logic [FRAME_BITS-1:0] r_tx_shift;
    logic [FRAME_BITS-2:0] r_rx_shift;
    logic [FRAME_BITS-1:0] r_rx_data;
    logic [3:0]            r_bit_cnt;
    logic                  r_done;
    logic                  w_cs_fall;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;

    assign w_cs_fall   = r_cs_d & ~i_cs;
    assign w_sclk_rise = i_sclk & ~r_sclk_d & ~i_cs;
    assign w_sclk_fall = ~i_sclk & r_sclk_d & ~i_cs;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk_d   <= 1'b0;
            r_cs_d     <= 1'b1;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_bit_cnt  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_sclk_d <= i_sclk;
            r_cs_d   <= i_cs;
            if (w_cs_fall) begin
                r_tx_shift <= i_tx_data;
                r_bit_cnt  <= '0;
                r_done     <= 1'b0;
            end else if (i_cs) begin
                // idle or aborted frame: drop partial data, keep last result and flags
                r_tx_shift <= '0;
                r_bit_cnt  <= '0;
            end else begin
                if (w_sclk_rise && r_bit_cnt != BITS) begin
                    r_rx_shift <= {r_rx_shift[FRAME_BITS-3:0], i_mosi};
                    r_bit_cnt  <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == BITS - 4'd1) begin
                        r_rx_data <= {r_rx_shift, i_mosi};
                        r_done    <= 1'b1;
                    end
                end
                if (w_sclk_fall) begin
                    r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign o_miso    = r_tx_shift[FRAME_BITS-1] & ~i_cs;
    assign o_rx_data = r_rx_data;
    assign o_tx_done = r_done;
    assign o_rx_done = r_done;

endmodule

// File: rtl/spi_master_slave.sv
// Self-contained SPI loop: one master and one slave sharing an internal mode-0 bus,
// with the bus brought out for observation.
module spi_master_slave
    import spi_pkg::*;
#(
    parameter int unsigned DIV_CLK = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FRAME_BITS-1:0] master_tx_data,
    input  logic [FRAME_BITS-1:0] slave_tx_data,
    output logic [FRAME_BITS-1:0] master_rx_data,
    output logic [FRAME_BITS-1:0] slave_rx_data,
    output logic                  master_tx_done,
    output logic                  master_rx_done,
    output logic                  slave_tx_done,
    output logic                  slave_rx_done,
    output logic                  spi_clk,
    output logic                  mosi,
    output logic                  miso,
    output logic                  cs
);

    logic w_spi_clk;
    logic w_mosi;
    logic w_miso;
    logic w_cs;

    spi_master #(
        .DIV_CLK(DIV_CLK)
    ) u_master (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_tx_data (master_tx_data),
        .i_miso    (w_miso),
        .o_sclk    (w_spi_clk),
        .o_mosi    (w_mosi),
        .o_cs      (w_cs),
        .o_rx_data (master_rx_data),
        .o_tx_done (master_tx_done),
        .o_rx_done (master_rx_done)
    );

    spi_slave u_slave (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_tx_data (slave_tx_data),
        .i_sclk    (w_spi_clk),
        .i_mosi    (w_mosi),
        .i_cs      (w_cs),
        .o_miso    (w_miso),
        .o_rx_data (slave_rx_data),
        .o_tx_done (slave_tx_done),
        .o_rx_done (slave_rx_done)
    );

    assign spi_clk = w_spi_clk;
    assign mosi    = w_mosi;
    assign miso    = w_miso;
    assign cs      = w_cs;

endmodule

// File: tb/tb_spi_master_slave.sv
// Directed bench: two copies of the SPI loop (DIV_CLK 2 and 5) share stimulus;
// each task checks one scenario against hand-computed values.
module tb_spi_master_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] m_tx = 8'h00;
    logic [7:0] s_tx = 8'h00;

    logic [7:0] m_rx2, s_rx2, m_rx5, s_rx5;
    logic       mtd2, mrd2, std2, srd2, sclk2, mosi2, miso2, cs2;
    logic       mtd5, mrd5, std5, srd5, sclk5, mosi5, miso5, cs5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_master_slave #(.DIV_CLK(2)) u_dut2 (
        .clk(clk), .reset(reset), .master_tx_data(m_tx), .slave_tx_data(s_tx),
        .master_rx_data(m_rx2), .slave_rx_data(s_rx2),
        .master_tx_done(mtd2), .master_rx_done(mrd2),
        .slave_tx_done(std2), .slave_rx_done(srd2),
        .spi_clk(sclk2), .mosi(mosi2), .miso(miso2), .cs(cs2)
    );

    spi_master_slave #(.DIV_CLK(5)) u_dut5 (
        .clk(clk), .reset(reset), .master_tx_data(m_tx), .slave_tx_data(s_tx),
        .master_rx_data(m_rx5), .slave_rx_data(s_rx5),
        .master_tx_done(mtd5), .master_rx_done(mrd5),
        .slave_tx_done(std5), .slave_rx_done(srd5),
        .spi_clk(sclk5), .mosi(mosi5), .miso(miso5), .cs(cs5)
    );

    task automatic pulse_reset(input logic [7:0] mtx, input logic [7:0] stx);
        @(negedge clk);
        reset = 1'b1;
        m_tx  = mtx;
        s_tx  = stx;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        m_tx  = 8'hA5;
        s_tx  = 8'h3C;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cs2, sclk2, mosi2, miso2} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s_bus2: got cs,sclk,mosi,miso=%b expected 1000", tag, {cs2, sclk2, mosi2, miso2});
        end
        n_tests++;
        if ({mtd2, mrd2, std2, srd2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s_flags2: got %b expected 0000", tag, {mtd2, mrd2, std2, srd2});
        end
        n_tests++;
        if (m_rx2 !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_mrx2: got %h expected 00", tag, m_rx2);
        end
        n_tests++;
        if (s_rx2 !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_srx2: got %h expected 00", tag, s_rx2);
        end
        n_tests++;
        if ({cs5, sclk5, mosi5, miso5} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s_bus5: got cs,sclk,mosi,miso=%b expected 1000", tag, {cs5, sclk5, mosi5, miso5});
        end
        n_tests++;
        if ({mtd5, mrd5, std5, srd5, m_rx5, s_rx5} !== 20'h0) begin
            n_fail++;
            $display("FAIL %s_state5: got flags=%b mrx=%h srx=%h expected all zero", tag,
                     {mtd5, mrd5, std5, srd5}, m_rx5, s_rx5);
        end
    endtask

    task automatic test_frame(input string tag, input logic [7:0] mtx, input logic [7:0] stx);
        int   done2_n = 0;
        int   done5_n = 0;
        int   rises = 0;
        int   viol_idle = 0;
        int   viol_mosi = 0;
        logic prev_sclk;
        logic prev_mosi;
        pulse_reset(mtx, stx);
        prev_sclk = sclk2;
        prev_mosi = mosi2;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            // inputs change after both sides have latched; the frame must not notice
            if (n == 5) begin
                m_tx = ~mtx;
                s_tx = ~stx;
            end
            if (cs2 && sclk2) viol_idle++;
            if (!prev_sclk && sclk2) begin
                if (!cs2) rises++;
                if (mosi2 !== prev_mosi) viol_mosi++;
            end
            prev_sclk = sclk2;
            prev_mosi = mosi2;
            if (done2_n == 0 && mtd2 === 1'b1) done2_n = n;
            if (done5_n == 0 && mtd5 === 1'b1) done5_n = n;
            if (n >= 100 && done5_n != 0) break;
        end
        n_tests++;
        if (s_rx2 !== mtx) begin
            n_fail++;
            $display("FAIL %s_srx2: got %b expected %b", tag, s_rx2, mtx);
        end
        n_tests++;
        if (m_rx2 !== stx) begin
            n_fail++;
            $display("FAIL %s_mrx2: got %b expected %b", tag, m_rx2, stx);
        end
        n_tests++;
        if ({mtd2, mrd2, std2, srd2} !== 4'b1111) begin
            n_fail++;
            $display("FAIL %s_flags2: got %b expected 1111", tag, {mtd2, mrd2, std2, srd2});
        end
        n_tests++;
        if (s_rx5 !== mtx) begin
            n_fail++;
            $display("FAIL %s_srx5: got %b expected %b", tag, s_rx5, mtx);
        end
        n_tests++;
        if (m_rx5 !== stx) begin
            n_fail++;
            $display("FAIL %s_mrx5: got %b expected %b", tag, m_rx5, stx);
        end
        n_tests++;
        if ({mtd5, mrd5, std5, srd5} !== 4'b1111) begin
            n_fail++;
            $display("FAIL %s_flags5: got %b expected 1111", tag, {mtd5, mrd5, std5, srd5});
        end
        n_tests++;
        if (done2_n < 36 || done2_n > 40) begin
            n_fail++;
            $display("FAIL %s_len2: got %0d cycles expected 36..40", tag, done2_n);
        end
        n_tests++;
        if (done5_n < 90 || done5_n > 94) begin
            n_fail++;
            $display("FAIL %s_len5: got %0d cycles expected 90..94", tag, done5_n);
        end
        n_tests++;
        if (rises != 8) begin
            n_fail++;
            $display("FAIL %s_rises: got %0d rising spi_clk with cs low expected 8", tag, rises);
        end
        n_tests++;
        if (viol_idle != 0) begin
            n_fail++;
            $display("FAIL %s_sclk_idle: got %0d cycles with spi_clk high and cs high expected 0", tag, viol_idle);
        end
        n_tests++;
        if (viol_mosi != 0) begin
            n_fail++;
            $display("FAIL %s_mosi_stable: got %0d mosi changes at rising spi_clk expected 0", tag, viol_mosi);
        end
    endtask

    task automatic test_abort;
        int rises = 0;
        logic prev_sclk;
        pulse_reset(8'hC3, 8'h5A);
        prev_sclk = sclk2;
        for (int n = 1; n <= 100 && rises < 3; n++) begin
            @(negedge clk);
            if (!prev_sclk && sclk2 && !cs2) rises++;
            prev_sclk = sclk2;
        end
        n_tests++;
        if (rises != 3) begin
            n_fail++;
            $display("FAIL abort_reach3: got %0d rising edges expected 3", rises);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({cs2, sclk2} !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_cs: got cs,sclk=%b expected 10", {cs2, sclk2});
        end
        n_tests++;
        if (s_rx2 !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_srx: got %h expected 00", s_rx2);
        end
        n_tests++;
        if ({mtd2, mrd2, std2, srd2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_flags: got %b expected 0000", {mtd2, mrd2, std2, srd2});
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset("reset_init");
        test_frame("frame_b7_ad", 8'b10110111, 8'b10101101);
        test_frame("frame_fb_89", 8'b11111011, 8'b10001001);
        test_reset("reset_after_frame");
        test_abort();
        test_frame("frame_ff_00", 8'hFF, 8'h00);
        test_frame("frame_00_ff", 8'h00, 8'hFF);
        test_frame("frame_back_to_back", 8'h81, 8'h7E);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
